// File: rtl/sample_packer.sv
`default_nettype none
// ============================================================================
// Module   : sample_packer
// Purpose  : Fast-clock front end of the acquisition path. Divides the sample
//            clock, captures the probe pins, compacts the enabled channels and
//            packs them LSB-first into 16-bit words for the sample FIFO write
//            port. A FIFO overflow latches a sticky stall that only reset
//            clears.
// Ports    : clk               fast sample clock (rising edge)
//            rst_n             synchronous active-low reset
//            probe[15:0]       raw probe pins
//            acq_enable        acquisition run/stop (already synchronized)
//            clock_divisor[7:0] sample period = clock_divisor+1 cycles
//            channel_enable[15:0] channel mask, bit i selects probe[i]
//            overflow          FIFO overflow flag
//            sample_data[15:0] packed word to FIFO din
//            sample_data_avail one-cycle FIFO write strobe
//            stalled           sticky overflow indication
// Options  : SAMPLE_PACKER_TEST_PATTERN_EN - replaces the probe register with
//            a 16-bit ramp counter (cleared on run start, +1 per strobe).
// Revision : 1.0 - initial release
// ============================================================================
module sample_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] probe,
  input  logic        acq_enable,
  input  logic [7:0]  clock_divisor,
  input  logic [15:0] channel_enable,
  input  logic        overflow,
  output logic [15:0] sample_data,
  output logic        sample_data_avail,
  output logic        stalled
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_STALL = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_acq_prev;
  logic [15:0] r_mask;
  logic [7:0]  r_div;
  logic [7:0]  r_div_cnt;
  logic [15:0] r_probe;
  logic        r_cap_valid;
  logic [30:0] r_acc;
  logic [3:0]  r_cnt;
  logic [15:0] r_sample_data;
  logic        r_avail;
  logic        r_stalled;

  logic        w_start;
  logic        w_stop;
  logic        w_strobe;
  logic [15:0] w_field;
  logic [4:0]  w_n;
  logic [4:0]  w_sum;
  logic [30:0] w_merged;

`ifdef SAMPLE_PACKER_TEST_PATTERN_EN
  logic [15:0] r_pat;
  logic        w_unused_probe;
  assign w_unused_probe = ^probe;
`endif

  assign w_start  = (r_state == S_IDLE) && acq_enable && !r_acq_prev;
  assign w_stop   = (r_state == S_RUN) && !acq_enable && r_acq_prev;
  // Strobes are gated by acq_enable so the last captured field always lands
  // in the accumulator while still in RUN, never colliding with the flush.
  assign w_strobe = (r_state == S_RUN) && acq_enable && (r_div_cnt == 8'd0);

  // Compaction: enabled channels in ascending order, lowest at bit 0.
  // w_n ends up as the popcount of the latched mask.
  always_comb begin
    w_field = '0;
    w_n     = '0;
    for (int i = 0; i < 16; i++) begin
      if (r_mask[i]) begin
        w_field[w_n[3:0]] = r_probe[i];
        w_n               = w_n + 5'd1;
      end
    end
  end

  // Bits at and above r_cnt are always zero, so OR-merging is safe.
  assign w_merged = r_acc | ({15'd0, w_field} << r_cnt);
  assign w_sum    = {1'b0, r_cnt} + w_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_acq_prev    <= 1'b0;
      r_mask        <= '0;
      r_div         <= '0;
      r_div_cnt     <= '0;
      r_probe       <= '0;
      r_cap_valid   <= 1'b0;
      r_acc         <= '0;
      r_cnt         <= '0;
      r_sample_data <= '0;
      r_avail       <= 1'b0;
      r_stalled     <= 1'b0;
`ifdef SAMPLE_PACKER_TEST_PATTERN_EN
      r_pat         <= '0;
`endif
    end else begin
      r_acq_prev  <= acq_enable;
      r_avail     <= 1'b0;
      r_cap_valid <= w_strobe;

`ifdef SAMPLE_PACKER_TEST_PATTERN_EN
      if (w_start) begin
        r_pat <= '0;
      end else if (w_strobe) begin
        r_probe <= r_pat;
        r_pat   <= r_pat + 16'd1;
      end
`else
      r_probe <= probe;
`endif

      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state   <= S_RUN;
            r_mask    <= channel_enable;
            r_div     <= clock_divisor;
            r_div_cnt <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
          end
        end
        S_RUN: begin
          r_div_cnt <= (r_div_cnt == r_div) ? 8'd0 : r_div_cnt + 8'd1;
          if (r_cap_valid) begin
            if (w_sum >= 5'd16) begin
              r_sample_data <= w_merged[15:0];
              r_avail       <= 1'b1;
              r_acc         <= w_merged >> 16;
            end else begin
              r_acc <= w_merged;
            end
            // Low nibble of the sum is the new fill count in both branches.
            r_cnt <= w_sum[3:0];
          end
          if (w_stop) begin
            r_state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (r_cnt != 4'd0) begin
            r_sample_data <= r_acc[15:0];
            r_avail       <= 1'b1;
          end
          r_acc   <= '0;
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
        default: begin
        end
      endcase

      // Overflow wins over everything above, including a same-cycle emit.
      if (overflow || (r_state == S_STALL)) begin
        r_state       <= S_STALL;
        r_stalled     <= 1'b1;
        r_avail       <= 1'b0;
        r_sample_data <= r_sample_data;
        r_cap_valid   <= 1'b0;
        r_div_cnt     <= r_div_cnt;
        r_acc         <= '0;
        r_cnt         <= '0;
      end
    end
  end

  assign sample_data       = r_sample_data;
  assign sample_data_avail = r_avail;
  assign stalled           = r_stalled;

endmodule
`default_nettype wire
